// File: rtl/tdm_pkg.sv
// tdm_pkg: shared TDM types used by the demultiplexer and the transmit serializer
package tdm_pkg;
    localparam int NCH = 4;
    typedef logic [1:0] slot_t;
    typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: TDM slot stream in, parallel channel frame out
interface tdm_demux4_if import tdm_pkg::*; #(parameter int W = 4);
    logic [W-1:0]     din;
    logic             din_en;
    logic             fsync;
    logic [NCH*W-1:0] y;
    logic             y_valid;
    logic             locked;
    logic             sync_err;
    modport master(output din, din_en, fsync, input y, y_valid, locked, sync_err);
    modport slave(input din, din_en, fsync, output y, y_valid, locked, sync_err);
endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter with enable, load-to-1 and clear
module tdm_slot_ctr import tdm_pkg::*; (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  load,
    input  logic  clr,
    output slot_t slot
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) slot <= '0;
        else if (clr) slot <= '0;
        else if (load) slot <= slot_t'(1);
        else if (en) slot <= slot + 1'b1;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM receiver steering slots into parallel channel words
module tdm_demux4 import tdm_pkg::*; #(parameter int W = 4) (
    input logic        clk,
    input logic        rst_n,
    tdm_demux4_if.slave bus
);
    state_t           state_q, state_d;
    slot_t            slot, sh_idx;
    logic             ld, clr, inc, sh_we, err, done;
    logic [W-1:0]     sh [NCH-1];
    logic [NCH*W-1:0] y_q;
    logic             y_valid_q, sync_err_q;
    tdm_slot_ctr u_ctr (.clk(clk), .rst_n(rst_n), .en(inc), .load(ld), .clr(clr), .slot(slot));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= HUNT;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        ld = 1'b0;
        clr = 1'b0;
        inc = 1'b0;
        sh_we = 1'b0;
        err = 1'b0;
        done = 1'b0;
        if (bus.din_en) begin
            if (bus.fsync) begin
                // a marker always restarts the frame; mid-frame it also flags misalignment
                ld = 1'b1;
                sh_we = 1'b1;
                err = state_q == LOCKED && slot != 2'd0;
                state_d = LOCKED;
            end else if (state_q == LOCKED) begin
                if (slot == 2'd0) begin
                    err = 1'b1;
                    clr = 1'b1;
                    state_d = HUNT;
                end else begin
                    inc = 1'b1;
                    sh_we = slot != 2'd3;
                    done = slot == 2'd3;
                end
            end
        end
    end
    assign sh_idx = bus.fsync ? slot_t'(0) : slot;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh <= '{default: '0};
            y_q <= '0;
            y_valid_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            if (sh_we) sh[sh_idx] <= bus.din;
            if (done) y_q <= {bus.din, sh[2], sh[1], sh[0]};
            y_valid_q <= done;
            sync_err_q <= err;
        end
    assign bus.y = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.sync_err = sync_err_q;
    assign bus.locked = state_q == LOCKED;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench with a frame-level reference model checked every cycle
module tb_tdm_demux4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] m_y = '0;
    logic m_valid = 1'b0, m_err = 1'b0, m_locked = 1'b0;
    logic [3:0] q[$];
    time t1, t2;
    tdm_demux4_if #(.W(4)) bus();
    tdm_demux4 #(.W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Compare against expectations for the edge just passed, then predict the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            m_y = '0;
            m_valid = 1'b0;
            m_err = 1'b0;
            m_locked = 1'b0;
            q.delete();
        end
        chk("model_y", {16'h0, bus.y}, {16'h0, m_y});
        chk("model_y_valid", {31'h0, bus.y_valid}, {31'h0, m_valid});
        chk("model_sync_err", {31'h0, bus.sync_err}, {31'h0, m_err});
        chk("model_locked", {31'h0, bus.locked}, {31'h0, m_locked});
        if (rst_n) begin
            m_valid = 1'b0;
            m_err = 1'b0;
            if (bus.din_en) begin
                if (bus.fsync) begin
                    m_err = m_locked && q.size() != 0;
                    m_locked = 1'b1;
                    q.delete();
                    q.push_back(bus.din);
                end else if (m_locked) begin
                    if (q.size() == 0) begin
                        m_err = 1'b1;
                        m_locked = 1'b0;
                    end else begin
                        q.push_back(bus.din);
                        if (q.size() == 4) begin
                            m_y = {q[3], q[2], q[1], q[0]};
                            m_valid = 1'b1;
                            q.delete();
                        end
                    end
                end
            end
        end
    end
    task automatic put(input logic [3:0] d, input logic f);
        bus.din = d;
        bus.fsync = f;
        bus.din_en = 1'b1;
        @(posedge clk);
        #2;
        bus.din_en = 1'b0;
        bus.fsync = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic frame(input logic [15:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            put(w[4*i +: 4], i == 0);
            if (maxgap > 0 && i < 3) idle($urandom_range(0, maxgap));
        end
    endtask
    initial begin
        bus.din = '0;
        bus.din_en = 1'b0;
        bus.fsync = 1'b0;
        #3 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_y", {16'h0, bus.y}, 32'h0);
        chk("rst_locked", {31'h0, bus.locked}, 32'h0);
        for (int i = 0; i < 3; i++) put(4'h9, 1'b0);
        chk("hunt_y", {16'h0, bus.y}, 32'h0);
        chk("hunt_locked", {31'h0, bus.locked}, 32'h0);
        chk("hunt_err", {31'h0, bus.sync_err}, 32'h0);
        frame(16'hDCBA, 0);
        chk("f1_y", {16'h0, bus.y}, 32'hDCBA);
        chk("f1_valid", {31'h0, bus.y_valid}, 32'h1);
        chk("f1_locked", {31'h0, bus.locked}, 32'h1);
        chk("f1_err", {31'h0, bus.sync_err}, 32'h0);
        idle(1);
        chk("f1_valid_drop", {31'h0, bus.y_valid}, 32'h0);
        frame(16'h4321, 0);
        t1 = $time;
        chk("cont_y0", {16'h0, bus.y}, 32'h4321);
        frame(16'h8765, 0);
        t2 = $time;
        chk("cont_y1", {16'h0, bus.y}, 32'h8765);
        chk("cont_period", t2 - t1, 32'd40);
        frame(16'h4321, 3);
        chk("gap_y0", {16'h0, bus.y}, 32'h4321);
        idle($urandom_range(0, 3));
        frame(16'h8765, 3);
        chk("gap_y1", {16'h0, bus.y}, 32'h8765);
        put(4'h1, 1'b1);
        put(4'h2, 1'b0);
        put(4'hE, 1'b1);
        chk("early_err", {31'h0, bus.sync_err}, 32'h1);
        chk("early_valid", {31'h0, bus.y_valid}, 32'h0);
        put(4'hF, 1'b0);
        put(4'h0, 1'b0);
        put(4'h1, 1'b0);
        chk("early_y", {16'h0, bus.y}, 32'h10FE);
        chk("early_valid2", {31'h0, bus.y_valid}, 32'h1);
        put(4'h7, 1'b0);
        chk("miss_err", {31'h0, bus.sync_err}, 32'h1);
        chk("miss_locked", {31'h0, bus.locked}, 32'h0);
        chk("miss_y", {16'h0, bus.y}, 32'h10FE);
        idle(1);
        chk("miss_err_drop", {31'h0, bus.sync_err}, 32'h0);
        frame(16'h4321, 0);
        chk("relock_y", {16'h0, bus.y}, 32'h4321);
        chk("relock_locked", {31'h0, bus.locked}, 32'h1);
        put(4'hA, 1'b1);
        put(4'hB, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_y", {16'h0, bus.y}, 32'h0);
        chk("arst_locked", {31'h0, bus.locked}, 32'h0);
        chk("arst_valid", {31'h0, bus.y_valid}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        frame(16'hDCBA, 0);
        chk("post_rst_y", {16'h0, bus.y}, 32'hDCBA);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receive-side counterpart of the 4:1 multiplexer. It takes a time-division-multiplexed word stream, one slot per strobe, with four slots per frame and a frame-sync marker on slot 0. Each slot is steered into its own channel register. A completed frame is presented as four parallel channel words with a one-cycle valid pulse. It sits at the far end of a TDM link whose transmitter scans its inputs with a 2-bit select.

## Interface
- W, 4, width of each slot word / channel
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din  in  W  slot word; sampled only when din_en=1
- din_en  in  1  slot strobe; one slot per high cycle; gaps of any length allowed
- fsync  in  1  frame marker; qualified by din_en; high only on slot 0
- y  out  4*W  channel outputs; y[W-1:0]=ch0 … y[4W-1:3W]=ch3; held between frames
- y_valid  out  1  one-cycle pulse when y is updated
- locked  out  1  receiver is aligned to frame boundaries
- sync_err  out  1  one-cycle pulse on an alignment violation

## Operation
- Internal state: FSM {HUNT, LOCKED}, 2-bit slot counter `slot`, shadow registers sh0..sh2 (W bits each).
- **HUNT:**
  - din_en with fsync=0: the word is ignored; no error.
  - din_en with fsync=1: sh0←din, slot←1, go to LOCKED.
- **LOCKED**, on each din_en:
  - fsync=1 and slot==0: sh0←din, slot←1.
  - fsync=1 and slot≠0 (early marker): pulse sync_err, discard the partial frame, sh0←din, slot←1, stay LOCKED.
  - fsync=0 and slot==0 (missing marker): pulse sync_err, go to HUNT, locked←0, word discarded.
  - fsync=0 and slot 1 or 2: sh[slot]←din, slot←slot+1.
  - fsync=0 and slot==3: y←{din, sh2, sh1, sh0}, pulse y_valid, slot wraps to 0.
- din_en=0: no state change. Shadow registers and y hold.
- y changes only on a completed, correctly aligned frame. Discarded partial frames never reach y.
- locked=1 exactly while the FSM is in LOCKED.
- slot is meaningful only in LOCKED; it is forced to 0 on entry to HUNT.

## Timing
- All outputs are registered. Reset values: y=0, y_valid=0, locked=0, sync_err=0; FSM=HUNT, slot=0, shadows=0.
- Reset acts immediately on rst_n falling, including mid-frame. The partial frame is lost. After release, the block re-hunts.
- **Latency:** the edge that samples slot 3 updates y. y_valid is high for the following cycle only.
- locked rises one cycle after the edge that samples the first fsync strobe.
- sync_err is high for exactly one cycle after the offending edge.
- With continuous din_en, y_valid pulses every 4 cycles.
- Back-to-back frames need no idle cycle. The slot-3 and the next slot-0 strobes may be adjacent.
- fsync without din_en is ignored in every state.

## Structure
- Shared package tdm_pkg holds:
  - NCH=4;
  - slot_t (2-bit);
  - state enum {HUNT, LOCKED}.
  - The transmit mux/serializer reuses this package.
- One sub-module: tdm_slot_ctr, a 2-bit counter with enable, sync load-to-1 and clear, owned by the FSM.
- Channel steering, shadow registers and output register stay in the top level.

## Test plan
All scenarios use W=4.
1. Reset, then strobes with fsync on the first: din=A,B,C,D → y=16'hDCBA, y_valid one cycle after the D edge, locked=1, sync_err=0.
2. Continuous din_en for two frames (1,2,3,4 then 5,6,7,8, fsync on 1 and 5) → y=16'h4321 then 16'h8765, y_valid pulses 4 cycles apart. Repeat with random 0–3 cycle gaps → same y values.
3. In HUNT, words 9,9,9 with fsync=0 → y=0, y_valid=0, locked=0, sync_err=0.
4. Locked; frame 1,2 then fsync early with E, followed by F,0,1 → sync_err pulse on the E strobe, no y_valid for the broken frame, then y=16'h10FE.
5. Locked; a slot-0 strobe arrives without fsync → sync_err pulse, locked=0, y keeps its previous value; the next fsync relocks.
6. Locked, after 2 slots: assert rst_n=0 asynchronously between clock edges → y=0, y_valid=0, locked=0 without waiting for clk. After release, a full frame A,B,C,D with fsync → y=16'hDCBA.
